blink_sequencer: RTL and testbench
==================================

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of phase-length inputs and internal timer.
REQ-002 SHALL have parameter NUM_W, default 4, width of blink-count input and blink counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  in  1  request to begin a sequence; sampled in IDLE only.
REQ-006 SHALL have port stop  in  1  synchronous abort of a running sequence.
REQ-007 SHALL have port en  in  1  timer enable; 0 freezes timer, state and light.
REQ-008 SHALL have port on_time  in  CNT_W  ON phase length minus 1, in enabled cycles.
REQ-009 SHALL have port off_time  in  CNT_W  OFF phase length minus 1, in enabled cycles.
REQ-010 SHALL have port blink_num  in  NUM_W  number of ON/OFF pairs; 0 means continuous.
REQ-011 SHALL have port light  out  1  registered LED drive.
REQ-012 SHALL have port busy  out  1  high while in ON or OFF.
REQ-013 SHALL have port done  out  1  one-cycle pulse at normal completion.

Function
REQ-014 SHALL implement states IDLE, ON, OFF, DONE.
REQ-015 SHALL, in IDLE with start=1 and stop=0, latch on_time, off_time and blink_num, clear timer and blink counter, and enter ON next cycle.
REQ-016 SHALL drive light=1 exactly when state is ON, registered, so light rises the cycle after start is sampled.
REQ-017 SHALL, in ON/OFF, increment the timer only on cycles with en=1; hold timer and state when en=0.
REQ-018 SHALL leave ON when en=1 and timer equals latched on_time: clear timer, enter OFF; ON lasts on_time+1 enabled cycles (on_time=0 gives one cycle).
REQ-019 SHALL leave OFF when en=1 and timer equals latched off_time: clear timer; if blink_num_q!=0 and blink counter equals blink_num_q-1, enter DONE, else increment blink counter and enter ON.
REQ-020 SHALL, in continuous mode (blink_num_q=0), never enter DONE and hold the blink counter at 0.
REQ-021 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-022 SHALL ignore start in ON, OFF and DONE; input changes after latching SHALL NOT affect the running sequence.
REQ-023 SHALL, on stop=1 in ON or OFF, enter IDLE next cycle regardless of en, clear timer, drop light, and not pulse done.
REQ-024 SHALL give stop priority over start and over phase expiry when coincident; start with stop in IDLE SHALL be ignored.
REQ-025 SHALL treat the timer as wrap-free: compare-equal terminates each phase before overflow for all input values.

Reset
REQ-026 SHALL, while reset=1, force state IDLE, timer 0, blink counter 0, latched registers 0, light=0, busy=0, done=0.
REQ-027 SHALL, on reset asserted mid-sequence, abandon it immediately without a done pulse.

Structure
REQ-028 SHALL place the state enumeration and default CNT_W/NUM_W constants in a shared blink package.
REQ-029 SHALL instantiate one sub-module blink_phase_timer (CNT_W counter with clear, enable, and terminal-match compare against a given limit).
REQ-030 SHALL keep all outputs registered; no combinational path from inputs to outputs.

Verification
REQ-031 Reset: reset=1 mid-ON with light=1 -> light, busy, done 0 asynchronously; state IDLE after release.
REQ-032 Basic: on_time=2, off_time=1, blink_num=2, en=1, start pulse -> light 1 for 3 cycles, 0 for 2, 1 for 3, 0 for 2, then done pulse of 1 cycle; busy high for 10 cycles.
REQ-033 Enable gating: on_time=3, en toggled 1/0 each cycle -> ON lasts 8 clocks, light stable during en=0 cycles.
REQ-034 Abort: blink_num=5, stop=1 in 2nd OFF phase -> IDLE next cycle, light 0, no done; new start accepted afterwards.
REQ-035 Continuous: blink_num=0, on_time=0, off_time=0 -> light alternates every cycle for 100 cycles, done never asserts; stop ends it.
REQ-036 Coincidence: start held high through the sequence and inputs changed mid-run -> original values used, new sequence starts only after done returns to IDLE.

Source files
------------

// File: rtl/blink_sequencer_pkg.sv
// Shared types and default widths for the blink sequencer and its phase timer.
package blink_sequencer_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int NUM_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } blink_state_t;

endpackage

// File: rtl/blink_phase_timer.sv
// Up-counting phase timer with synchronous clear, count enable and a
// compare-equal terminal match against the supplied limit.
module blink_phase_timer
    import blink_sequencer_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_match
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The phase ends on equality, so the count never passes the limit and cannot wrap.
    assign o_match = (r_count == i_limit);

endmodule

// File: rtl/blink_sequencer.sv
// LED blink sequencer: latches phase lengths and pair count on start, then
// alternates ON/OFF phases until the pair count is reached, stop, or reset.
//
// state   | meaning
// IDLE    | waiting for start, timer held clear
// ON      | light driven, timing on_time+1 enabled cycles
// OFF     | light dark, timing off_time+1 enabled cycles
// DONE    | single-cycle done pulse, then back to IDLE
module blink_sequencer
    import blink_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic [CNT_W-1:0] on_time,
    input  logic [CNT_W-1:0] off_time,
    input  logic [NUM_W-1:0] blink_num,
    output logic             light,
    output logic             busy,
    output logic             done
);

    blink_state_t     r_state;
    blink_state_t     w_next_state;
    logic [CNT_W-1:0] r_on_q;
    logic [CNT_W-1:0] r_off_q;
    logic [NUM_W-1:0] r_num_q;
    logic [NUM_W-1:0] r_blink_cnt;
    logic             r_light;
    logic             r_busy;
    logic             r_done;

    logic             w_latch;
    logic             w_cnt_inc;
    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic             w_match;
    logic             w_last_pair;
    logic [CNT_W-1:0] w_limit;

    assign w_tmr_en    = en && ((r_state == ST_ON) || (r_state == ST_OFF));
    assign w_limit     = (r_state == ST_OFF) ? r_off_q : r_on_q;
    assign w_last_pair = (r_num_q != '0) && (r_blink_cnt == (r_num_q - 1'b1));

    blink_phase_timer #(
        .W(CNT_W)
    ) u_timer (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_limit (w_limit),
        .o_match (w_match)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Stop is tested before expiry so an abort always wins over a phase change.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_cnt_inc    = 1'b0;
        w_tmr_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_clr = 1'b1;
                if (start && !stop) begin
                    w_latch      = 1'b1;
                    w_next_state = ST_ON;
                end
            end
            ST_ON: begin
                if (stop) begin
                    w_tmr_clr    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (en && w_match) begin
                    w_tmr_clr    = 1'b1;
                    w_next_state = ST_OFF;
                end
            end
            ST_OFF: begin
                if (stop) begin
                    w_tmr_clr    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (en && w_match) begin
                    w_tmr_clr = 1'b1;
                    if (w_last_pair) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_cnt_inc    = (r_num_q != '0);
                        w_next_state = ST_ON;
                    end
                end
            end
            ST_DONE: begin
                w_tmr_clr    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_tmr_clr    = 1'b1;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_on_q      <= '0;
            r_off_q     <= '0;
            r_num_q     <= '0;
            r_blink_cnt <= '0;
        end else begin
            if (w_latch) begin
                r_on_q      <= on_time;
                r_off_q     <= off_time;
                r_num_q     <= blink_num;
                r_blink_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_light <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_light <= (w_next_state == ST_ON);
            r_busy  <= (w_next_state == ST_ON) || (w_next_state == ST_OFF);
            r_done  <= (w_next_state == ST_DONE);
        end
    end

    assign light = r_light;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer: directed scenarios plus random
// stimulus, compared every cycle against a phase/remaining-cycles model.
module tb_blink_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       en;
    logic [3:0] on_time;
    logic [3:0] off_time;
    logic [3:0] blink_num;
    logic       light;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    blink_sequencer #(
        .CNT_W(4),
        .NUM_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .on_time   (on_time),
        .off_time  (off_time),
        .blink_num (blink_num),
        .light     (light),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase name, enabled cycles left in the phase, pairs left.
    localparam int M_IDLE = 0;
    localparam int M_ON   = 1;
    localparam int M_OFF  = 2;
    localparam int M_DONE = 3;

    int m_mode;
    int m_left;
    int m_pairs;
    int m_on;
    int m_off;
    bit m_cont;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_left  = 0;
        m_pairs = 0;
        m_on    = 0;
        m_off   = 0;
        m_cont  = 1'b0;
    endtask

    task automatic model_step();
        case (m_mode)
            M_IDLE: begin
                if (start && !stop) begin
                    m_on    = int'(on_time);
                    m_off   = int'(off_time);
                    m_pairs = int'(blink_num);
                    m_cont  = (blink_num == 4'd0);
                    m_mode  = M_ON;
                    m_left  = m_on + 1;
                end
            end
            M_ON: begin
                if (stop) begin
                    m_mode = M_IDLE;
                end else if (en) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_OFF;
                        m_left = m_off + 1;
                    end
                end
            end
            M_OFF: begin
                if (stop) begin
                    m_mode = M_IDLE;
                end else if (en) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (!m_cont) m_pairs--;
                        if (!m_cont && m_pairs == 0) begin
                            m_mode = M_DONE;
                        end else begin
                            m_mode = M_ON;
                            m_left = m_on + 1;
                        end
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        check_eq("light", 32'(light), 32'(m_mode == M_ON));
        check_eq("busy",  32'(busy),  32'(m_mode == M_ON || m_mode == M_OFF));
        check_eq("done",  32'(done),  32'(m_mode == M_DONE));
    endtask

    // One clock: drive inputs after the previous edge, advance model on the edge, check #1 later.
    task automatic tick(input logic s, input logic p, input logic e, input int on, input int off, input int num);
        start     = s;
        stop      = p;
        en        = e;
        on_time   = 4'(on);
        off_time  = 4'(off);
        blink_num = 4'(num);
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    int cnt_a;
    int cnt_b;
    int first_done;
    int off_entries;
    int prev_mode;

    initial begin
        reset = 1'b1;
        start = 1'b0; stop = 1'b0; en = 1'b0;
        on_time = '0; off_time = '0; blink_num = '0;
        model_reset();
        #1;
        check_eq("rst_light", 32'(light), 32'd0);
        check_eq("rst_busy",  32'(busy),  32'd0);
        check_eq("rst_done",  32'(done),  32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        tick(0, 0, 1, 0, 0, 0);

        // Basic: 3 on, 2 off, twice, then one done cycle.
        cnt_a = 0; cnt_b = 0;
        tick(1, 0, 1, 2, 1, 2);
        if (busy) cnt_a++;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 1, 9, 9, 9);
            if (busy) cnt_a++;
            if (done) cnt_b++;
        end
        check_eq("basic_busy_cycles", 32'(cnt_a), 32'd10);
        check_eq("basic_done_pulses", 32'(cnt_b), 32'd1);

        // Enable gating: on_time=3 with en alternating gives 8 clocks of ON.
        cnt_a = 0;
        tick(1, 0, 1, 3, 0, 1);
        if (light) cnt_a++;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, logic'(i % 2), 3, 0, 1);
            if (light) cnt_a++;
        end
        check_eq("gate_on_clocks", 32'(cnt_a), 32'd8);

        // Abort in the second OFF phase.
        off_entries = 0; cnt_b = 0;
        tick(1, 0, 1, 1, 2, 5);
        prev_mode = m_mode;
        for (int i = 0; i < 40 && off_entries < 2; i++) begin
            tick(0, 0, 1, 1, 2, 5);
            if (m_mode == M_OFF && prev_mode != M_OFF) off_entries++;
            prev_mode = m_mode;
        end
        check_eq("abort_reached_off2", 32'(off_entries), 32'd2);
        tick(0, 1, 1, 1, 2, 5);
        check_eq("abort_light", 32'(light), 32'd0);
        check_eq("abort_busy",  32'(busy),  32'd0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 1, 1, 2, 5);
            if (done) cnt_b++;
        end
        check_eq("abort_no_done", 32'(cnt_b), 32'd0);
        tick(1, 0, 1, 1, 2, 5);
        check_eq("restart_light", 32'(light), 32'd1);
        tick(0, 1, 0, 1, 2, 5);

        // Continuous mode with single-cycle phases.
        cnt_b = 0;
        tick(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            tick(0, 0, 1, 0, 0, 0);
            check_eq("cont_alt", 32'(light), 32'(i % 2 == 1));
            if (done) cnt_b++;
        end
        check_eq("cont_no_done", 32'(cnt_b), 32'd0);
        tick(0, 1, 1, 0, 0, 0);
        check_eq("cont_stop_busy", 32'(busy), 32'd0);

        // Start held high with inputs changing mid-run.
        first_done = -1;
        tick(1, 0, 1, 1, 1, 2);
        for (int i = 1; i <= 14; i++) begin
            tick(1, 0, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            if (done && first_done < 0) first_done = i;
        end
        check_eq("hold_first_done", 32'(first_done), 32'd8);
        tick(0, 1, 1, 0, 0, 0);

        // Widest phases: 16 enabled cycles each, no wrap.
        cnt_a = 0;
        tick(1, 0, 1, 15, 15, 1);
        if (light) cnt_a++;
        for (int i = 0; i < 34; i++) begin
            tick(0, 0, 1, 0, 0, 0);
            if (light) cnt_a++;
        end
        check_eq("max_on_clocks", 32'(cnt_a), 32'd16);

        // Asynchronous reset mid-ON.
        tick(1, 0, 1, 5, 1, 0);
        tick(0, 0, 1, 5, 1, 0);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_light", 32'(light), 32'd0);
        check_eq("async_rst_busy",  32'(busy),  32'd0);
        check_eq("async_rst_done",  32'(done),  32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        tick(0, 0, 1, 5, 1, 0);
        check_eq("post_rst_idle", 32'(busy), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic s, p, e;
            int on, off, num;
            s   = ($urandom_range(0, 3) == 0);
            p   = ($urandom_range(0, 19) == 0);
            e   = s || ($urandom_range(0, 3) != 0);
            on  = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            off = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            num = int'($urandom_range(0, 3));
            tick(s, p, e, on, off, num);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
